// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, sign fix-up stage.
// Optional build macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle product.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic            iFlush,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [XLEN-1:0]     result_q;
  logic                isDiv_q;
  logic                selHi_q;
  logic                neg_q;
  logic [XLEN-1:0]     opB_q;
  logic [XLEN-1:0]     dvd_q;
  logic [2*XLEN-1:0]   prod_q;
  logic [XLEN:0]       rem_q;

  logic                isDiv;
  logic                aSigned;
  logic                bSigned;
  logic                aNeg;
  logic                bNeg;
  logic                selHi;
  logic                negRes;
  logic                divZero;
  logic                divOvf;
  logic                special;
  logic [XLEN-1:0]     aMag;
  logic [XLEN-1:0]     bMag;
  logic [XLEN-1:0]     specialRes;

  // Operand decode at capture: selHi picks the high product half or the remainder.
  always_comb begin
    isDiv      = iFunct3[2];
    aSigned    = isDiv ? ~iFunct3[0] : (iFunct3[1] ^ iFunct3[0]);
    bSigned    = isDiv ? ~iFunct3[0] : (iFunct3[1:0] == 2'b01);
    aNeg       = aSigned & iA[XLEN-1];
    bNeg       = bSigned & iB[XLEN-1];
    aMag       = aNeg ? -iA : iA;
    bMag       = bNeg ? -iB : iB;
    selHi      = isDiv ? iFunct3[1] : (iFunct3[1:0] != 2'b00);
    negRes     = (isDiv && iFunct3[1]) ? aNeg : (aNeg ^ bNeg);
    divZero    = isDiv && (iB == '0);
    divOvf     = isDiv && !iFunct3[0] && (iA == MinNeg) && (iB == '1);
    special    = divZero || divOvf;
    if (divZero) begin
      specialRes = iFunct3[1] ? iA : '1;
    end else begin
      specialRes = iFunct3[1] ? '0 : iA;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fastA;
  logic signed [XLEN:0]     fastB;
  logic signed [2*XLEN-1:0] fastProd;
  logic [XLEN-1:0]          fastRes;

  always_comb begin
    fastA    = {aSigned & iA[XLEN-1], iA};
    fastB    = {bSigned & iB[XLEN-1], iB};
    fastProd = (2*XLEN)'(fastA) * (2*XLEN)'(fastB);
    fastRes  = (iFunct3[1:0] == 2'b00) ? fastProd[XLEN-1:0] : fastProd[2*XLEN-1:XLEN];
  end
`endif

  logic [XLEN:0]       mulSum;
  logic [2*XLEN-1:0]   prod_d;
  logic [XLEN+1:0]     remShift;
  logic                remGe;
  logic [XLEN:0]       rem_d;
  logic [XLEN-1:0]     dvd_d;

  // One radix-2 step; the multiplier lives in the low product half and shifts out as the sum shifts in.
  always_comb begin
    mulSum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, opB_q};
    prod_d   = prod_q[0] ? {mulSum, prod_q[XLEN-1:1]} : {1'b0, prod_q[2*XLEN-1:1]};
    remShift = {rem_q, dvd_q[XLEN-1]};
    remGe    = (remShift >= {2'b00, opB_q});
    rem_d    = remGe ? (XLEN+1)'(remShift - {2'b00, opB_q}) : remShift[XLEN:0];
    dvd_d    = {dvd_q[XLEN-2:0], remGe};
  end

  logic [2*XLEN-1:0]   prodFix;
  logic [XLEN-1:0]     quoFix;
  logic [XLEN-1:0]     remFix;
  logic [XLEN-1:0]     fixRes;

  always_comb begin
    prodFix = neg_q ? -prod_q : prod_q;
    quoFix  = neg_q ? -dvd_q : dvd_q;
    remFix  = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    if (isDiv_q) begin
      fixRes = selHi_q ? remFix : quoFix;
    end else begin
      fixRes = selHi_q ? prodFix[2*XLEN-1:XLEN] : prodFix[XLEN-1:0];
    end
  end

  // A DONE cycle accepts iStart exactly like IDLE so back-to-back operations have no bubble.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      isDiv_q  <= 1'b0;
      selHi_q  <= 1'b0;
      neg_q    <= 1'b0;
      opB_q    <= '0;
      dvd_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
    end else if (iFlush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (iStart) begin
            isDiv_q <= isDiv;
            selHi_q <= selHi;
            neg_q   <= negRes;
            cnt_q   <= '0;
            if (special) begin
              result_q <= specialRes;
              state_q  <= DONE;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!isDiv) begin
              result_q <= fastRes;
              state_q  <= DONE;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
            end
`endif
            else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
              opB_q   <= isDiv ? bMag : aMag;
              prod_q  <= {{XLEN{1'b0}}, bMag};
              dvd_q   <= aMag;
              rem_q   <= '0;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        CALC: begin
          if (isDiv_q) begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
          end else begin
            prod_q <= prod_d;
          end
          if (cnt_q == CW'(XLEN-1)) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        FIX: begin
          result_q <= fixRes;
          state_q  <= DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oResult = result_q;

endmodule
